// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and line geometry for the memory-port arbiters.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arbState_t;
  typedef enum logic {REQ_I, REQ_D} reqId_t;
  localparam int LINE_BYTES = 8;
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; on contention the side not granted last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic   reqI,
  input  logic   reqD,
  input  reqId_t lastGrant,
  output logic   grantValid,
  output reqId_t grantId
);
  always_comb begin
    grantValid = reqI | reqD;
    grantId    = reqId_t'(reqD && !(reqI && lastGrant == REQ_D));
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit memory port between instruction refill and data access,
// one transaction in flight, round-robin on contention, per-transaction timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter bit DATA_FIRST     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic        iDone,
  output logic [63:0] iRData,
  input  logic        dReq,
  input  logic        dWrite,
  input  logic [31:0] dAddr,
  input  logic [63:0] dWData,
  input  logic [7:0]  dByteEn,
  output logic        dDone,
  output logic [63:0] dRData,
  output logic        memReq,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [63:0] memWData,
  output logic [7:0]  memByteEn,
  input  logic        memAck,
  input  logic [63:0] memRData,
  output logic        busError
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arbState_t   state_q, state_d;
  reqId_t      last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d, mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_be_q, mem_be_d;
  logic        i_done_q, i_done_d, d_done_q, d_done_d;
  logic [63:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        grant_valid, grant_d, finish;
  reqId_t      grant_id;

  rr_pick2 u_pick (
    .reqI      (iReq),
    .reqD      (dReq),
    .lastGrant (last_q),
    .grantValid(grant_valid),
    .grantId   (grant_id)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = bus_err_q;
    grant_d     = grant_id == REQ_D;
    finish      = memAck || cnt_q == CNT_LAST;
    case (state_q)
      IDLE: if (grant_valid) begin
        state_d     = grant_d ? BUSY_D : BUSY_I;
        last_d      = grant_id;
        cnt_d       = '0;
        mem_req_d   = 1'b1;
        mem_addr_d  = (grant_d ? dAddr : iAddr) & LINE_MASK;
        mem_write_d = grant_d && dWrite;
        mem_wdata_d = grant_d ? dWData : '0;
        mem_be_d    = (grant_d && dWrite) ? dByteEn : 8'hFF;
      end
      BUSY_I, BUSY_D: if (finish) begin
        // an ack on the timeout cycle still counts as a normal completion
        state_d   = RESP;
        mem_req_d = 1'b0;
        i_done_d  = state_q == BUSY_I;
        d_done_d  = state_q == BUSY_D;
        bus_err_d = bus_err_q || !memAck;
        if (memAck && state_q == BUSY_I) i_rdata_d = memRData;
        if (memAck && state_q == BUSY_D && !mem_write_q) d_rdata_d = memRData;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= DATA_FIRST ? REQ_I : REQ_D;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign memReq    = mem_req_q;
  assign memWrite  = mem_write_q;
  assign memAddr   = mem_addr_q;
  assign memWData  = mem_wdata_q;
  assign memByteEn = mem_be_q;
  assign iDone     = i_done_q;
  assign dDone     = d_done_q;
  assign iRData    = i_rdata_q;
  assign dRData    = d_rdata_q;
  assign busError  = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level model compared every cycle, plus directed literal checks.
module tb_mem_port_arbiter;
  localparam int TO = 16;
  localparam bit DF = 1'b1;

  logic        clk = 1'b0, reset;
  logic        iReq = 0, dReq = 0, dWrite = 0, memAck;
  logic [31:0] iAddr = 0, dAddr = 0;
  logic [63:0] dWData = 0, memRData;
  logic [7:0]  dByteEn = 0;
  logic        iDone, dDone, memReq, memWrite, busError;
  logic [63:0] iRData, dRData, memWData;
  logic [31:0] memAddr;
  logic [7:0]  memByteEn;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  int ack_delay = -1, cnt_r = 0;
  logic resp_ack = 0, force_ack = 0;
  logic [63:0] rd_val = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .DATA_FIRST(DF)) dut (
    .clk(clk), .reset(reset),
    .iReq(iReq), .iAddr(iAddr), .iDone(iDone), .iRData(iRData),
    .dReq(dReq), .dWrite(dWrite), .dAddr(dAddr), .dWData(dWData), .dByteEn(dByteEn),
    .dDone(dDone), .dRData(dRData),
    .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWData(memWData),
    .memByteEn(memByteEn), .memAck(memAck), .memRData(memRData), .busError(busError)
  );

  always #5 clk = ~clk;
  assign memAck   = resp_ack | force_ack;
  assign memRData = rd_val;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory responder: acks on the (ack_delay+1)-th cycle memReq is seen high
  always begin
    @(posedge clk); #1;
    if (memReq) begin
      cnt_r++;
      resp_ack = ack_delay >= 0 && cnt_r == ack_delay + 1;
    end else begin
      cnt_r = 0;
      resp_ack = 0;
    end
  end

  // transaction-level model
  logic        m_req, m_write, m_idone, m_ddone, m_err;
  logic [31:0] m_addr;
  logic [63:0] m_wdata, m_irdata, m_drdata;
  logic [7:0]  m_be;
  bit          m_last;

  task automatic model_clear();
    m_req = 0; m_write = 0; m_idone = 0; m_ddone = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0; m_be = 0;
    m_last = !DF;
  endtask

  task automatic step(output bit alive);
    @(posedge clk or negedge reset);
    alive = (reset === 1'b1);
  endtask

  initial begin
    bit alive, got, who;
    int n;
    forever begin
      model_clear();
      wait (reset === 1'b1);
      alive = 1;
      while (alive) begin
        step(alive);
        if (alive && (iReq || dReq)) begin
          who = (iReq && dReq) ? !m_last : dReq;
          m_last = who;
          m_req = 1;
          m_addr = (who ? dAddr : iAddr) & 32'hFFFF_FFF8;
          m_write = who && dWrite;
          m_wdata = who ? dWData : 64'h0;
          m_be = (who && dWrite) ? dByteEn : 8'hFF;
          n = 0; got = 0;
          while (alive && !got) begin
            step(alive);
            if (alive) begin
              n++;
              if (memAck) begin
                got = 1;
                if (!who) m_irdata = memRData;
                else if (!m_write) m_drdata = memRData;
              end else if (n == TO) begin
                got = 1;
                m_err = 1;
              end
            end
          end
          if (alive) begin
            m_req = 0;
            m_idone = !who;
            m_ddone = who;
            step(alive);
            if (alive) begin m_idone = 0; m_ddone = 0; end
          end
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("memReq", memReq, m_req);
    chk("memWrite", memWrite, m_write);
    chk("memAddr", memAddr, m_addr);
    chk("memWData", memWData, m_wdata);
    chk("memByteEn", memByteEn, m_be);
    chk("iDone", iDone, m_idone);
    chk("dDone", dDone, m_ddone);
    chk("iRData", iRData, m_irdata);
    chk("dRData", dRData, m_drdata);
    chk("busError", busError, m_err);
  end

  task automatic do_req(input bit is_d, input bit wr, input logic [31:0] a, input logic [63:0] wd,
                        input logic [7:0] be, output int lat, output int nreq, output logic [31:0] ma,
                        output logic [7:0] mbe, output logic mw, output logic [63:0] mwd);
    @(posedge clk); #1;
    if (is_d) begin dReq = 1; dWrite = wr; dAddr = a; dWData = wd; dByteEn = be; end
    else begin iReq = 1; iAddr = a; end
    lat = 0; nreq = 0; ma = 0; mbe = 0; mw = 0; mwd = 0;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin iAddr = ~a; dAddr = ~a; dWData = ~wd; dByteEn = ~be; end
      if (memReq) begin
        if (nreq == 0) begin ma = memAddr; mbe = memByteEn; mw = memWrite; mwd = memWData; end
        nreq++;
      end
      if (is_d ? dDone : iDone) lat = k;
    end
    if (is_d) dReq = 0; else iReq = 0;
    chk("done_seen", lat != 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, nreq, no, ndone;
    int ord[4];
    logic [31:0] ma;
    logic [7:0] mbe;
    logic mw;
    logic [63:0] mwd;
    reset = 1;
    #1 reset = 0;
    #1 chk_en = 1;
    idle(3);
    chk("reset_memReq", memReq, 0);
    chk("reset_busError", busError, 0);
    reset = 1;
    idle(1);

    // contention twice: expect D,I,D,I
    ack_delay = 2; rd_val = 64'h1111;
    no = 0;
    repeat (2) begin
      @(posedge clk); #1;
      iReq = 1; iAddr = 32'h0000_0100; dReq = 1; dWrite = 0; dAddr = 32'h0000_0208;
      for (int k = 0; k < 60 && (iReq || dReq); k++) begin
        @(posedge clk); #1;
        if (dDone) begin dReq = 0; if (no < 4) ord[no] = 1; no++; end
        if (iDone) begin iReq = 0; if (no < 4) ord[no] = 0; no++; end
      end
    end
    chk("contention_count", no, 4);
    chk("order0_D", ord[0], 1);
    chk("order1_I", ord[1], 0);
    chk("order2_D", ord[2], 1);
    chk("order3_I", ord[3], 0);
    idle(2);

    // single instruction read, ack 3 cycles after memReq
    ack_delay = 3; rd_val = 64'hDEAD_BEEF_0123_4567;
    do_req(0, 0, 32'h0000_104C, 0, 0, lat, nreq, ma, mbe, mw, mwd);
    chk("rd_memAddr", ma, 32'h0000_1048);
    chk("rd_memByteEn", mbe, 8'hFF);
    chk("rd_memWrite", mw, 0);
    chk("rd_latency", lat, 5);
    chk("rd_memReq_cycles", nreq, 4);
    chk("rd_iRData", iRData, 64'hDEAD_BEEF_0123_4567);
    idle(2);

    // store: dRData must keep the earlier load value
    ack_delay = 1; rd_val = 64'h5555_5555_5555_5555;
    do_req(1, 1, 32'h0000_2003, 64'h0000_0000_AA00_0000, 8'h08, lat, nreq, ma, mbe, mw, mwd);
    chk("st_memWrite", mw, 1);
    chk("st_memAddr", ma, 32'h0000_2000);
    chk("st_memByteEn", mbe, 8'h08);
    chk("st_memWData", mwd, 64'h0000_0000_AA00_0000);
    chk("st_latency", lat, 3);
    chk("st_dRData", dRData, 64'h1111);
    idle(2);

    // timeout: never ack
    ack_delay = -1; rd_val = 64'h6666;
    do_req(1, 0, 32'h0000_3010, 0, 0, lat, nreq, ma, mbe, mw, mwd);
    chk("to_memReq_cycles", nreq, TO);
    chk("to_latency", lat, TO + 1);
    chk("to_busError", busError, 1);
    chk("to_dRData", dRData, 64'h1111);
    idle(3);
    chk("to_busError_sticky", busError, 1);

    // ack on the last allowed cycle after a fresh reset
    reset = 0;
    idle(2);
    reset = 1;
    idle(1);
    ack_delay = TO - 1; rd_val = 64'h7777;
    do_req(1, 0, 32'h0000_3018, 0, 0, lat, nreq, ma, mbe, mw, mwd);
    chk("edge_memReq_cycles", nreq, TO);
    chk("edge_busError", busError, 0);
    chk("edge_dRData", dRData, 64'h7777);
    idle(2);

    // reset two cycles into BUSY_I
    ack_delay = -1;
    @(posedge clk); #1;
    iReq = 1; iAddr = 32'h0000_4000;
    idle(2);
    chk("mid_memReq_before", memReq, 1);
    #1 reset = 0;
    #1 chk("mid_memReq_async", memReq, 0);
    idle(1);
    iReq = 0;
    idle(1);
    reset = 1;
    idle(1);
    force_ack = 1;
    idle(1);
    force_ack = 0;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      if (iDone || dDone) ndone++;
    end
    chk("mid_stray_done", ndone, 0);
    ack_delay = 1; rd_val = 64'h9999;
    do_req(0, 0, 32'h0000_5008, 0, 0, lat, nreq, ma, mbe, mw, mwd);
    chk("mid_next_latency", lat, 3);
    chk("mid_next_iRData", iRData, 64'h9999);
    idle(2);

    // back-to-back loads with immediate ack: done every 3 cycles
    ack_delay = 0; rd_val = 64'hB2B0;
    ndone = 0;
    @(posedge clk); #1;
    dReq = 1; dWrite = 0; dAddr = 32'h0000_6000;
    for (int k = 1; k <= 30; k++) begin
      idle(1);
      if (dDone) begin
        ndone++;
        chk("b2b_phase", k % 3, 2);
      end
    end
    dReq = 0;
    chk("b2b_count", ndone, 10);
    chk("b2b_dRData", dRData, 64'hB2B0);
    idle(4);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
